// File: rtl/uart_rx_word_assembler_pkg.sv
// rtl/uart_rx_word_assembler_pkg.sv - shared types and defaults for the UART RX word assembler
package uart_rx_word_assembler_pkg;

  typedef enum logic {
    AsmIdle,
    AsmCollecting
  } asm_state_t;

  localparam int DEF_WORD_BYTES     = 4;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 50000;

  function automatic int word_width(input int bytes);
    return 8 * bytes;
  endfunction

endpackage

// File: rtl/uart_rx_word_assembler_if.sv
// rtl/uart_rx_word_assembler_if.sv - byte-in / word-out bundle of the UART RX word assembler
interface uart_rx_word_assembler_if
  import uart_rx_word_assembler_pkg::*;
#(
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  logic [7:0]                    rx_byte;
  logic                          rx_complete;
  logic [8*WORD_BYTES-1:0]       word_o;
  logic                          word_valid_o;
  logic                          word_ready_i;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count_o;
  logic                          overflow_o;
  logic                          timeout_o;

  modport master (
    input  rx_byte, rx_complete, word_ready_i,
    output word_o, word_valid_o, fifo_count_o, overflow_o, timeout_o
  );

  modport slave (
    output rx_byte, rx_complete, word_ready_i,
    input  word_o, word_valid_o, fifo_count_o, overflow_o, timeout_o
  );
endinterface

// File: rtl/uart_rx_word_assembler_word_fifo.sv
// rtl/uart_rx_word_assembler_word_fifo.sv - synchronous show-ahead FIFO for assembled words
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     sourceClk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];
  assign count    = count_q;

  always_ff @(posedge sourceClk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_word_assembler.sv
// rtl/uart_rx_word_assembler.sv - packs UART RX bytes little-endian into words and queues them
module uart_rx_word_assembler
  import uart_rx_word_assembler_pkg::*;
#(
  parameter int WORD_BYTES     = DEF_WORD_BYTES,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                  sourceClk,
  input logic                  reset,
  uart_rx_word_assembler_if.master bus
);
  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int IDX_W  = $clog2(WORD_BYTES);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  asm_state_t        state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;
  logic [WORD_W-1:0] shreg, shreg_n;
  logic [WORD_W-1:0] push_word;
  logic              push;
  logic              expire;
  logic              pop;
  logic              overflow_q;
  logic              timeout_q;

  logic [WORD_W-1:0] head;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;

  always_ff @(posedge sourceClk or posedge reset) begin
    if (reset) begin
      state      <= AsmIdle;
      idx        <= '0;
      tmo_cnt    <= '0;
      shreg      <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      tmo_cnt    <= tmo_cnt_n;
      shreg      <= shreg_n;
      overflow_q <= push && full && !pop;
      timeout_q  <= expire;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    tmo_cnt_n = tmo_cnt;
    shreg_n   = shreg;
    push_word = shreg;
    push      = 1'b0;
    expire    = 1'b0;
    case (state)
      AsmIdle: begin
        if (bus.rx_complete) begin
          shreg_n      = '0;
          shreg_n[7:0] = bus.rx_byte;
          idx_n        = IDX_W'(1);
          tmo_cnt_n    = '0;
          state_n      = AsmCollecting;
        end
      end
      AsmCollecting: begin
        // Byte strobe is checked first so it wins over a coinciding expiry.
        if (bus.rx_complete) begin
          tmo_cnt_n = '0;
          for (int b = 0; b < WORD_BYTES; b++) begin
            if (idx == IDX_W'(b)) begin
              shreg_n[8*b +: 8] = bus.rx_byte;
            end
          end
          if (idx == IDX_W'(WORD_BYTES - 1)) begin
            push      = 1'b1;
            push_word = shreg_n;
            idx_n     = '0;
            state_n   = AsmIdle;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          expire  = 1'b1;
          idx_n   = '0;
          shreg_n = '0;
          state_n = AsmIdle;
        end else begin
          tmo_cnt_n = tmo_cnt + TMO_W'(1);
        end
      end
      default: state_n = AsmIdle;
    endcase
  end

  assign pop = !empty && bus.word_ready_i;

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .sourceClk (sourceClk),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign bus.word_o       = head;
  assign bus.word_valid_o = !empty;
  assign bus.fifo_count_o = count;
  assign bus.overflow_o   = overflow_q;
  assign bus.timeout_o    = timeout_q;
endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// tb/tb_uart_rx_word_assembler.sv - self-checking bench for uart_rx_word_assembler
module tb_uart_rx_word_assembler;
  localparam int WB      = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 100;

  logic sourceClk = 1'b0;
  logic reset     = 1'b1;
  always #5 sourceClk = ~sourceClk;

  uart_rx_word_assembler_if #(.WORD_BYTES(WB), .FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_word_assembler #(
    .WORD_BYTES     (WB),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .sourceClk (sourceClk),
    .reset     (reset),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  int ovf_seen = 0;
  int to_seen = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  partial[$];
  int          idle_cycles = 0;
  logic        exp_ovf = 1'b0;
  logic        exp_to = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes collect into a list, 100 quiet cycles drop it, full words queue.
  always @(posedge sourceClk) begin
    logic        do_pop;
    logic        do_push;
    logic [31:0] w;
    exp_ovf = 1'b0;
    exp_to  = 1'b0;
    if (reset) begin
      exp_q.delete();
      partial.delete();
      idle_cycles = 0;
    end else begin
      do_pop  = (exp_q.size() > 0) && bus.word_ready_i;
      do_push = 1'b0;
      w       = '0;
      if (bus.rx_complete) begin
        partial.push_back(bus.rx_byte);
        idle_cycles = 0;
        if (partial.size() == WB) begin
          for (int i = 0; i < WB; i++) w = w | (32'(partial[i]) << (8 * i));
          partial.delete();
          if (exp_q.size() < DEPTH || do_pop) do_push = 1'b1;
          else exp_ovf = 1'b1;
        end
      end else if (partial.size() > 0) begin
        idle_cycles++;
        if (idle_cycles == TIMEOUT) begin
          partial.delete();
          idle_cycles = 0;
          exp_to = 1'b1;
        end
      end
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(w);
    end
  end

  always @(negedge sourceClk) begin
    if (!reset) begin
      check("valid", 32'(bus.word_valid_o), 32'(exp_q.size() > 0));
      check("count", 32'(bus.fifo_count_o), 32'(exp_q.size()));
      if (exp_q.size() > 0) check("word", bus.word_o, exp_q[0]);
      check("overflow", 32'(bus.overflow_o), 32'(exp_ovf));
      check("timeout", 32'(bus.timeout_o), 32'(exp_to));
      if (bus.overflow_o) ovf_seen++;
      if (bus.timeout_o) to_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sourceClk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte     = b;
    bus.rx_complete = 1'b1;
    tick(1);
    bus.rx_complete = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < WB; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    bus.word_ready_i = 1'b1;
    while (bus.word_valid_o && guard < 10) begin
      tick(1);
      guard++;
    end
    bus.word_ready_i = 1'b0;
    check("drain_done", 32'(bus.word_valid_o), 32'd0);
  endtask

  logic [31:0] words_a[5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
  logic [31:0] words_b[5] = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3, 32'hE0E1E2E3};

  initial begin
    int ovf_base;
    int to_base;
    bus.rx_byte      = 8'h00;
    bus.rx_complete  = 1'b0;
    bus.word_ready_i = 1'b0;
    #1;
    check("rst_valid", 32'(bus.word_valid_o), 32'd0);
    check("rst_count", 32'(bus.fifo_count_o), 32'd0);
    check("rst_word", bus.word_o, 32'd0);
    check("rst_ovf", 32'(bus.overflow_o), 32'd0);
    check("rst_to", 32'(bus.timeout_o), 32'd0);
    tick(3);
    reset = 1'b0;
    tick(1);

    // 1: basic little-endian packing
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check("t1_word", bus.word_o, 32'h12345678);
    check("t1_valid", 32'(bus.word_valid_o), 32'd1);
    check("t1_count", 32'(bus.fifo_count_o), 32'd1);
    drain();

    // 2: overflow on the fifth word, then ordered drain
    ovf_base = ovf_seen;
    for (int i = 0; i < 5; i++) send_word(words_a[i]);
    tick(1);
    check("t2_count", 32'(bus.fifo_count_o), 32'd4);
    check("t2_ovf_pulses", 32'(ovf_seen - ovf_base), 32'd1);
    bus.word_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_word", bus.word_o, words_a[i]);
      tick(1);
    end
    bus.word_ready_i = 1'b0;
    check("t2_empty", 32'(bus.word_valid_o), 32'd0);

    // 3: push into full FIFO coinciding with a pop
    ovf_base = ovf_seen;
    for (int i = 0; i < 4; i++) send_word(words_b[i]);
    send_byte(8'hE3); send_byte(8'hE2); send_byte(8'hE1);
    bus.word_ready_i = 1'b1;
    send_byte(8'hE0);
    bus.word_ready_i = 1'b0;
    check("t3_count", 32'(bus.fifo_count_o), 32'd4);
    tick(1);
    check("t3_no_ovf", 32'(ovf_seen - ovf_base), 32'd0);
    bus.word_ready_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("t3_drain_word", bus.word_o, words_b[i]);
      tick(1);
    end
    bus.word_ready_i = 1'b0;

    // 4: timeout after exactly 100 idle cycles discards the partial word
    to_base = to_seen;
    send_byte(8'hF1); send_byte(8'hF2);
    tick(TIMEOUT);
    tick(1);
    check("t4_to_pulses", 32'(to_seen - to_base), 32'd1);
    send_word(32'hDDCCBBAA);
    check("t4_word", bus.word_o, 32'hDDCCBBAA);
    check("t4_count", 32'(bus.fifo_count_o), 32'd1);
    drain();

    // 5: strobe on the last idle cycle before expiry wins
    to_base = to_seen;
    send_byte(8'h01);
    tick(TIMEOUT - 1);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("t5_word", bus.word_o, 32'h04030201);
    check("t5_no_to", 32'(to_seen - to_base), 32'd0);
    drain();

    // 6: reset mid-word with words queued
    ovf_base = ovf_seen;
    to_base  = to_seen;
    send_word(32'h0BADF00D); send_word(32'hCAFEBABE);
    send_byte(8'h99); send_byte(8'h88); send_byte(8'h77);
    reset = 1'b1;
    #1;
    check("t6_valid", 32'(bus.word_valid_o), 32'd0);
    check("t6_count", 32'(bus.fifo_count_o), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(1);
    send_word(32'h87654321);
    check("t6_word", bus.word_o, 32'h87654321);
    check("t6_count_after", 32'(bus.fifo_count_o), 32'd1);
    check("t6_no_pulses", 32'(ovf_seen - ovf_base + to_seen - to_base), 32'd0);
    drain();
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
